// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator: mode encodings and idle level.
package parity_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE     = 2'b00,
    PARITY_ODD      = 2'b01,
    PARITY_EVEN     = 2'b10,
    PARITY_NONE_ALT = 2'b11
  } parity_mode_e;

  // Line mark level: driven in reset and in the no-parity modes.
  localparam logic PARITY_IDLE = 1'b1;

endpackage

// File: rtl/parity_xor_reduce.sv
// Balanced XOR-reduction tree over a DATA_WIDTH-bit word (purely combinational).
module xor_reduce #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_x
);

  localparam int unsigned LEVELS = $clog2(DATA_WIDTH);
  localparam int unsigned LEAVES = 1 << LEVELS;

  // Pad to a power of two with zeros so every tree level halves cleanly.
  logic [LEAVES-1:0] w_leaf;

  always_comb begin
    w_leaf                 = '0;
    w_leaf[DATA_WIDTH-1:0] = i_data;
  end

  if (LEVELS == 0) begin : g_single
    assign o_x = w_leaf[0];
  end else begin : g_tree
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int unsigned NODES = LEAVES >> (l + 1);
      logic [NODES-1:0] w_v;
      for (genvar k = 0; k < NODES; k++) begin : g_node
        if (l == 0) begin : g_first
          assign w_v[k] = w_leaf[2*k] ^ w_leaf[2*k+1];
        end else begin : g_next
          assign w_v[k] = g_lvl[l-1].w_v[2*k] ^ g_lvl[l-1].w_v[2*k+1];
        end
      end
    end
    assign o_x = g_lvl[LEVELS-1].w_v[0];
  end

endmodule

// File: rtl/parity.sv
// Registered parity generator: odd, even or no-parity (mark) per ParityType.
module parity
  import parity_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] RegIn,
  input  logic [1:0]            ParityType,
  output logic                  ParityOut
);

  logic w_x;
  logic w_parity;
  logic r_parity;

  xor_reduce #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_xor_reduce (
    .i_data(RegIn),
    .o_x   (w_x)
  );

  always_comb begin
    w_parity = PARITY_IDLE;
    case (parity_mode_e'(ParityType))
      PARITY_ODD:      w_parity = ~w_x;
      PARITY_EVEN:     w_parity = w_x;
      PARITY_NONE:     w_parity = PARITY_IDLE;
      PARITY_NONE_ALT: w_parity = PARITY_IDLE;
      default:         w_parity = PARITY_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_parity <= PARITY_IDLE;
    end else begin
      r_parity <= w_parity;
    end
  end

  assign ParityOut = r_parity;

endmodule

// File: tb/tb_parity.sv
// Directed and randomised checks of the parity generator at widths 8 and 32.
module tb_parity;

  logic        Clock;
  logic        Reset;
  logic [7:0]  RegIn8;
  logic [31:0] RegIn32;
  logic [1:0]  ParityType;
  logic        ParityOut8;
  logic        ParityOut32;

  int unsigned n_total;
  int unsigned n_pass;

  parity #(.DATA_WIDTH(8)) dut8 (
    .Clock     (Clock),
    .Reset     (Reset),
    .RegIn     (RegIn8),
    .ParityType(ParityType),
    .ParityOut (ParityOut8)
  );

  parity #(.DATA_WIDTH(32)) dut32 (
    .Clock     (Clock),
    .Reset     (Reset),
    .RegIn     (RegIn32),
    .ParityType(ParityType),
    .ParityOut (ParityOut32)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: count ones explicitly, then apply the mode rule.
  function automatic logic ref_parity(input logic [1:0] mode, input logic [31:0] data);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < 32; i++) ones += int'(data[i]);
    case (mode)
      2'b01:   return (ones % 2 == 0) ? 1'b1 : 1'b0;
      2'b10:   return (ones % 2 == 1) ? 1'b1 : 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; RegIn8 = 8'hFF; RegIn32 = 32'hFFFF_FFFF; ParityType = 2'b10;
    for (int c = 0; c < 2; c++) begin
      step();
      n_total++;
      if (ParityOut8 !== 1'b1) $display("FAIL reset_hold8 cycle %0d: got %b expected 1", c, ParityOut8);
      else n_pass++;
      n_total++;
      if (ParityOut32 !== 1'b1) $display("FAIL reset_hold32 cycle %0d: got %b expected 1", c, ParityOut32);
      else n_pass++;
    end
    Reset = 1'b0;
    step();
    n_total++;
    if (ParityOut8 !== 1'b0) $display("FAIL reset_release8: got %b expected 0", ParityOut8);
    else n_pass++;
  endtask

  task automatic test_odd();
    ParityType = 2'b01;
    RegIn8 = 8'b0001_0111;
    step();
    n_total++;
    if (ParityOut8 !== 1'b1) $display("FAIL odd_4ones: got %b expected 1", ParityOut8);
    else n_pass++;
    RegIn8 = 8'b0000_0001;
    step();
    n_total++;
    if (ParityOut8 !== 1'b0) $display("FAIL odd_1one: got %b expected 0", ParityOut8);
    else n_pass++;
  endtask

  task automatic test_even();
    ParityType = 2'b10;
    RegIn8 = 8'b1010_1111;
    step();
    n_total++;
    if (ParityOut8 !== 1'b0) $display("FAIL even_6ones: got %b expected 0", ParityOut8);
    else n_pass++;
    RegIn8 = 8'b0000_0111;
    step();
    n_total++;
    if (ParityOut8 !== 1'b1) $display("FAIL even_3ones: got %b expected 1", ParityOut8);
    else n_pass++;
  endtask

  task automatic test_none();
    logic [1:0] modes [2];
    logic [7:0] words [2];
    modes[0] = 2'b00; modes[1] = 2'b11;
    words[0] = 8'b1011_1101; words[1] = 8'b0000_0001;
    for (int m = 0; m < 2; m++) begin
      for (int w = 0; w < 2; w++) begin
        ParityType = modes[m];
        RegIn8     = words[w];
        step();
        n_total++;
        if (ParityOut8 !== 1'b1)
          $display("FAIL none_mode%b_word%h: got %b expected 1", modes[m], words[w], ParityOut8);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    logic       exp   [4];
    words[0] = 8'h01; words[1] = 8'h03; words[2] = 8'h01; words[3] = 8'h03;
    exp[0] = 1'b1; exp[1] = 1'b0; exp[2] = 1'b1; exp[3] = 1'b0;
    ParityType = 2'b10;
    RegIn8 = 8'h00;
    step();
    for (int i = 0; i < 4; i++) begin
      RegIn8 = words[i];
      // Output must still reflect the previous word before the edge.
      #3;
      n_total++;
      if (i > 0 && ParityOut8 !== exp[i-1])
        $display("FAIL b2b_prev%0d: got %b expected %b", i, ParityOut8, exp[i-1]);
      else if (i == 0 && ParityOut8 !== 1'b0)
        $display("FAIL b2b_prev0: got %b expected 0", ParityOut8);
      else n_pass++;
      step();
      n_total++;
      if (ParityOut8 !== exp[i]) $display("FAIL b2b_%0d: got %b expected %b", i, ParityOut8, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    ParityType = 2'b01; RegIn8 = 8'h01;
    step();
    n_total++;
    if (ParityOut8 !== 1'b0) $display("FAIL midrst_pre: got %b expected 0", ParityOut8);
    else n_pass++;
    Reset = 1'b1;
    step();
    n_total++;
    if (ParityOut8 !== 1'b1) $display("FAIL midrst_assert: got %b expected 1", ParityOut8);
    else n_pass++;
    Reset = 1'b0; RegIn8 = 8'h07;
    step();
    n_total++;
    if (ParityOut8 !== 1'b0) $display("FAIL midrst_release: got %b expected 0", ParityOut8);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0]  mode;
    logic [31:0] d32;
    logic [7:0]  d8;
    for (int i = 0; i < 1000; i++) begin
      mode = 2'($urandom_range(0, 3));
      d32  = $urandom;
      d8   = 8'($urandom);
      ParityType = mode; RegIn8 = d8; RegIn32 = d32;
      step();
      n_total++;
      if (ParityOut8 !== ref_parity(mode, {24'h0, d8}))
        $display("FAIL rand8 i=%0d mode=%b data=%h: got %b expected %b",
                 i, mode, d8, ParityOut8, ref_parity(mode, {24'h0, d8}));
      else n_pass++;
      n_total++;
      if (ParityOut32 !== ref_parity(mode, d32))
        $display("FAIL rand32 i=%0d mode=%b data=%h: got %b expected %b",
                 i, mode, d32, ParityOut32, ref_parity(mode, d32));
      else n_pass++;
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    Reset = 1'b1; RegIn8 = '0; RegIn32 = '0; ParityType = 2'b00;
    #2;
    test_reset();
    test_odd();
    test_even();
    test_none();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
